// File: rtl/genetico_pkg.sv
// Shared widths, FSM state type and the logic-element operator table
// for the chromosome fitness evaluator.
package genetico_pkg;

  localparam int CHROM_W = 103;
  localparam int LE_W    = 11;
  localparam int N_LES   = 9;
  localparam int OUT_W   = 4;
  localparam int N_IN    = 2;
  localparam int N_VEC   = 4;
  localparam int FIT_W   = 3;

  // Node space of the phenotype: primary inputs first, then one node per LE.
  localparam int N_NODES = N_IN + N_LES;

  // LE field layout, MSB first: {src_a, src_b, op}.
  localparam int SRC_W = 4;
  localparam int OP_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Boolean function selected by an LE's op field.
  function automatic logic le_op(input logic [OP_W-1:0] op, input logic a, input logic b);
    logic r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fenotipo.sv
// Combinational phenotype: a feed-forward chain of 9 two-input logic
// elements decoded from the chromosome. An LE may only read primary inputs
// or earlier LEs; any source index that is not yet defined reads input 0,
// which keeps the network acyclic for every possible chromosome.
module fenotipo
  import genetico_pkg::*;
(
  input  logic               i_processing,
  input  logic [N_IN-1:0]    i_chrom_in,
  input  logic [CHROM_W-1:0] i_chrom,
  output logic               o_chrom_out
);

  // Select node 'sel' if it is below 'lim', otherwise fall back to node 0.
  function automatic logic pick(input logic [N_NODES-1:0] nodes,
                                input logic [SRC_W-1:0]   sel,
                                input int                 lim);
    logic r;
    r = nodes[0];
    for (int k = 0; k < N_NODES; k++) begin
      if ((k < lim) && (SRC_W'(k) == sel)) r = nodes[k];
    end
    return r;
  endfunction

  // Evaluate the whole network for one input vector.
  function automatic logic eval_net(input logic [CHROM_W-1:0] chrom,
                                    input logic [N_IN-1:0]    vin);
    logic [N_NODES-1:0] nodes;
    logic [LE_W-1:0]    fld;
    logic [SRC_W-1:0]   osel;
    logic               a;
    logic               b;
    nodes = '0;
    nodes[N_IN-1:0] = vin;
    for (int j = 0; j < N_LES; j++) begin
      fld = chrom[j*LE_W +: LE_W];
      a = pick(nodes, fld[LE_W-1 -: SRC_W], N_IN + j);
      b = pick(nodes, fld[LE_W-1-SRC_W -: SRC_W], N_IN + j);
      nodes[N_IN+j] = le_op(fld[OP_W-1:0], a, b);
    end
    osel = chrom[CHROM_W-1 -: OUT_W];
    return pick(nodes, osel, N_NODES);
  endfunction

  // Output is forced low whenever no evaluation is in progress.
  always_comb begin
    o_chrom_out = 1'b0;
    if (i_processing) o_chrom_out = eval_net(i_chrom, i_chrom_in);
  end

endmodule

// File: rtl/fitness_evaluator.sv
// Applies the four input vectors to the phenotype of a latched chromosome,
// scores each against a latched target truth table and reports the count of
// matches with a one-cycle done pulse.
module fitness_evaluator
  import genetico_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CHROM_W-1:0] cromossomo_in,
  input  logic [N_VEC-1:0]   target,
  output logic               ready,
  output logic               done,
  output logic [FIT_W-1:0]   fitness,
  output logic               perfect,
  output logic [N_VEC-1:0]   mismatch_mask
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CHROM_W-1:0] r_chrom;
  logic [N_VEC-1:0]   r_target;
  logic [N_VEC-1:0]   r_mask;
  logic [FIT_W-1:0]   r_score;
  logic [N_IN-1:0]    r_vec;
  logic [CNT_W-1:0]   r_settle;

  logic               w_processing;
  logic [N_IN-1:0]    w_chrom_in;
  logic               w_chrom_out;
  logic               w_match;
  logic               w_settled;
  logic               w_last;
  logic [FIT_W-1:0]   w_score_nxt;
  logic [N_VEC-1:0]   w_mask_nxt;

  // Score increment that sticks at N_VEC instead of wrapping.
  function automatic logic [FIT_W-1:0] sat_inc(input logic [FIT_W-1:0] s);
    logic [FIT_W-1:0] r;
    if (s >= FIT_W'(N_VEC)) r = FIT_W'(N_VEC);
    else                    r = s + 1'b1;
    return r;
  endfunction

  fenotipo u_fenotipo (
    .i_processing (w_processing),
    .i_chrom_in   (w_chrom_in),
    .i_chrom      (r_chrom),
    .o_chrom_out  (w_chrom_out)
  );

  assign w_settled = (r_settle == CNT_W'(SETTLE_CYCLES - 1));
  assign w_last    = (r_vec == N_IN'(N_VEC - 1));
  assign w_match   = (w_chrom_out == r_target[r_vec]);

  // Score and mask as they will be after the current SAMPLE cycle.
  always_comb begin
    w_score_nxt = r_score;
    w_mask_nxt  = r_mask;
    if (w_match) w_score_nxt = sat_inc(r_score);
    else         w_mask_nxt[r_vec] = 1'b1;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_nxt  = r_state;
    ready        = 1'b0;
    done         = 1'b0;
    w_processing = 1'b0;
    w_chrom_in   = '0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = S_APPLY;
      end
      S_APPLY: begin
        w_processing = 1'b1;
        w_chrom_in   = r_vec;
        if (w_settled) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_processing = 1'b1;
        w_chrom_in   = r_vec;
        w_state_nxt  = w_last ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latched operands, vector index, settle counter and running score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chrom  <= '0;
      r_target <= '0;
      r_score  <= '0;
      r_mask   <= '0;
      r_vec    <= '0;
      r_settle <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chrom  <= cromossomo_in;
            r_target <= target;
            r_score  <= '0;
            r_mask   <= '0;
            r_vec    <= '0;
            r_settle <= '0;
          end
        end
        S_APPLY: begin
          if (!w_settled) r_settle <= r_settle + 1'b1;
        end
        S_SAMPLE: begin
          r_score <= w_score_nxt;
          r_mask  <= w_mask_nxt;
          if (!w_last) begin
            r_vec    <= r_vec + 1'b1;
            r_settle <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers load only on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fitness       <= '0;
      perfect       <= 1'b0;
      mismatch_mask <= '0;
    end else if ((r_state == S_SAMPLE) && w_last) begin
      fitness       <= w_score_nxt;
      perfect       <= (w_score_nxt == FIT_W'(N_VEC));
      mismatch_mask <= w_mask_nxt;
    end
  end

endmodule

// File: doc/fitness_evaluator.md
FITNESS_EVALUATOR -- requirements
Module: fitness_evaluator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state is clocked on the rising clock edge.
REQ-002 Parameter SETTLE_CYCLES, default 2, number of cycles (>=1) each input vector is held before the output is sampled.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to evaluate; accepted only when ready=1.
REQ-006 cromossomo_in  input  103  chromosome to evaluate; 9 LE fields of 11 bits at [98:0] plus 4-bit output selector at [102:99].
REQ-007 target  input  4  expected truth table; target[i] is the required chromOut for chromIn=i.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 fitness  output  3  number of matching vectors, 0..4.
REQ-011 perfect  output  1  high when fitness=4.
REQ-012 mismatch_mask  output  4  bit i set when vector i did not match.

Function
REQ-013 FSM states SHALL be IDLE, APPLY, SAMPLE, DONE.
REQ-014 IDLE, start=1 at edge k: latch cromossomo_in and target, clear score and mask, vector index=0, settle count=0, go APPLY.
REQ-015 APPLY: drive chromIn=vector index to the phenotype for SETTLE_CYCLES cycles, then go SAMPLE.
REQ-016 SAMPLE (one cycle): compare chromOut to latched target[index]; match -> score+1, else set mask[index]; index=3 -> DONE, else index+1 and APPLY with settle count=0.
REQ-017 On the edge entering DONE, fitness, perfect and mismatch_mask SHALL register the final score and mask; done=1 for exactly the DONE cycle; next state IDLE.
REQ-018 Latency: done SHALL be high in the cycle beginning at edge k+4*(SETTLE_CYCLES+1).
REQ-019 fitness, perfect, mismatch_mask SHALL hold their values until the next DONE entry; they do not change on start acceptance.
REQ-020 start while not in IDLE (APPLY, SAMPLE, DONE) SHALL be ignored; no queuing.
REQ-021 cromossomo_in and target changes after acceptance SHALL NOT affect the running evaluation.
REQ-022 The phenotype processing input SHALL be high in APPLY and SAMPLE, low otherwise.
REQ-023 chromIn SHALL be 0 outside APPLY/SAMPLE.
REQ-024 Score SHALL be 3-bit unsigned and never wrap (max 4).

Reset
REQ-025 rst SHALL force, immediately and regardless of state: state IDLE, ready=1, done=0, fitness=0, perfect=0, mismatch_mask=0, latched chromosome/target=0, chromIn=0, processing=0.
REQ-026 Reset asserted mid-evaluation SHALL abort it with no done pulse; after release the block SHALL accept start on the first clock edge.

Structure
REQ-027 Package genetico_pkg SHALL hold CHROM_W=103, LE_W=11, N_LES=9, OUT_W=4, N_IN=2, N_VEC=4, FIT_W=3 and the FSM state enum.
REQ-028 The block SHALL instantiate exactly one sub-module, fenotipo, fed from the latched chromosome; the rest is the FSM, counters and result registers.

Verification
REQ-029 Chromosome C, target = bench model truth table of C, SETTLE_CYCLES=2, start accepted edge 0 -> done at edge 12, fitness=4, perfect=1, mask=0000.
REQ-030 Same C, target = bitwise inverse of model table -> fitness=0, perfect=0, mask=1111; target with only bit 2 inverted -> fitness=3, mask=0100.
REQ-031 start re-pulsed at edges 3 and 12, target changed at edge 5 -> single done at edge 12, result from original target; ready low edges 1..12.
REQ-032 rst asserted at edge 7 of an evaluation -> done never pulses, fitness stays 0, ready=1 during reset; start after release completes normally in 12 cycles.
REQ-033 Back-to-back: start held high continuously -> accepted at edges 0 and 14 (IDLE at 13), two done pulses at edges 12 and 26, fitness of the first held from edge 12 until edge 26.
